// File: rtl/xbar_pkg.sv
// Shared constants, state encodings and slice helper for the registered stream crossbar.
package xbar_pkg;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    typedef enum logic [1:0] {
        RT_IDLE = 2'd0,
        RT_BUSY = 2'd1,
        RT_DROP = 2'd2
    } route_state_t;

    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_t;

    // Low bit of lane idx in a flat vector of equal-width lanes.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/stream_xbar_reg_if.sv
// Flat slave-side and master-side stream buses of the crossbar.
interface stream_xbar_reg_if #(
    parameter int unsigned T_DATA_WIDTH = 8,
    parameter int unsigned S_DATA_COUNT = 3,
    parameter int unsigned M_DATA_COUNT = 5,
    parameter int unsigned T_ID___WIDTH = $clog2(S_DATA_COUNT),
    parameter int unsigned T_DEST_WIDTH = $clog2(M_DATA_COUNT)
);
    logic [T_DATA_WIDTH*S_DATA_COUNT-1:0] s_data_i;
    logic [T_DEST_WIDTH*S_DATA_COUNT-1:0] s_dest_i;
    logic [S_DATA_COUNT-1:0]              s_last_i;
    logic [S_DATA_COUNT-1:0]              s_valid_i;
    logic [S_DATA_COUNT-1:0]              s_ready_o;
    logic [S_DATA_COUNT-1:0]              s_drop_o;
    logic [T_DATA_WIDTH*M_DATA_COUNT-1:0] m_data_o;
    logic [T_ID___WIDTH*M_DATA_COUNT-1:0] m_id_o;
    logic [M_DATA_COUNT-1:0]              m_last_o;
    logic [M_DATA_COUNT-1:0]              m_valid_o;
    logic [M_DATA_COUNT-1:0]              m_ready_i;

    // The crossbar itself.
    modport slave (
        input  s_data_i, s_dest_i, s_last_i, s_valid_i, m_ready_i,
        output s_ready_o, s_drop_o, m_data_o, m_id_o, m_last_o, m_valid_o
    );

    // The surrounding producers/consumers.
    modport master (
        output s_data_i, s_dest_i, s_last_i, s_valid_i, m_ready_i,
        input  s_ready_o, s_drop_o, m_data_o, m_id_o, m_last_o, m_valid_o
    );

endinterface

// File: rtl/xbar_arbiter.sv
// Packet-atomic arbiter for one master port: same-cycle grant, lock held until the last beat.
module xbar_arbiter
    import xbar_pkg::*;
#(
    parameter int unsigned S_COUNT  = 3,
    parameter int unsigned IDX_W    = 2,
    parameter int unsigned ARB_MODE = ARB_RR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [S_COUNT-1:0] req,
    input  logic [S_COUNT-1:0] req_last,
    input  logic               advance,
    output logic [S_COUNT-1:0] grant_c,
    output logic [IDX_W-1:0]   sel_c
);

    arb_state_t       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] pick;
    logic             found;
    logic             xfer;
    logic             xfer_last;

    // Fixed priority is a round-robin search that always starts at slave 0.
    always_comb begin
        base  = (ARB_MODE == ARB_FIXED) ? IDX_W'(S_COUNT - 1) : rr_ptr;
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned off = 1; off <= S_COUNT; off++) begin
            cand = IDX_W'((32'(base) + off) % S_COUNT);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        grant_c = '0;
        sel_c   = pick;
        if (state == ARB_LOCKED) begin
            sel_c          = owner;
            grant_c[owner] = req[owner];
        end else if (found) begin
            grant_c[pick] = 1'b1;
        end
    end

    assign xfer      = (|grant_c) & advance;
    assign xfer_last = |(grant_c & req_last);

    // Lock on a first beat without last; unlock and move the pointer on the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ARB_UNLOCKED;
            owner  <= '0;
            rr_ptr <= IDX_W'(S_COUNT - 1);
        end else if (xfer) begin
            if (xfer_last) begin
                state  <= ARB_UNLOCKED;
                rr_ptr <= sel_c;
            end else if (state == ARB_UNLOCKED) begin
                state <= ARB_LOCKED;
                owner <= sel_c;
            end
        end
    end

endmodule

// File: rtl/stream_xbar_reg.sv
// Registered stream crossbar: per-slave route latching, out-of-range drop,
// per-master packet-atomic arbitration and a single output register per master.
module stream_xbar_reg
    import xbar_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 8,
    parameter int unsigned S_DATA_COUNT = 3,
    parameter int unsigned M_DATA_COUNT = 5,
    parameter int unsigned T_ID___WIDTH = $clog2(S_DATA_COUNT),
    parameter int unsigned T_DEST_WIDTH = $clog2(M_DATA_COUNT),
    parameter int unsigned ARB_MODE     = ARB_RR
) (
    input  logic              clk,
    input  logic              rst,
    stream_xbar_reg_if.slave  bus
);

    localparam int unsigned W  = T_DATA_WIDTH;
    localparam int unsigned S  = S_DATA_COUNT;
    localparam int unsigned M  = M_DATA_COUNT;
    localparam int unsigned IW = T_ID___WIDTH;
    localparam int unsigned DW = T_DEST_WIDTH;

    logic [W-1:0]          s_data [S];
    logic [DW-1:0]         target [S];
    logic [S-1:0]          drop_c;
    logic [S-1:0]          fwd_c;
    logic [S-1:0]          ready_c;
    logic [M-1:0][S-1:0]   req;
    logic [M-1:0][S-1:0]   grant;
    logic [IW-1:0]         sel [M];
    logic [M-1:0]          stage_ready;

    for (genvar gi = 0; gi < S; gi++) begin : g_slv
        route_state_t  state;
        logic [DW-1:0] route;
        logic [DW-1:0] dest;
        logic          bad_dest;
        logic          accept;
        logic [M-1:0]  hit;

        assign s_data[gi] = bus.s_data_i[slice_lo(gi, W) +: W];
        assign dest       = bus.s_dest_i[slice_lo(gi, DW) +: DW];
        assign bad_dest   = 32'(dest) >= M;

        // A busy slave follows its latched route; only first beats look at s_dest_i.
        assign target[gi] = (state == RT_BUSY) ? route : dest;
        assign drop_c[gi] = bus.s_valid_i[gi] &
                            ((state == RT_DROP) | ((state == RT_IDLE) & bad_dest));
        assign fwd_c[gi]  = bus.s_valid_i[gi] & ~drop_c[gi];

        for (genvar gj = 0; gj < M; gj++) begin : g_hit
            assign hit[gj] = grant[gj][gi] & stage_ready[gj];
        end

        assign ready_c[gi] = drop_c[gi] | (|hit);
        assign accept      = bus.s_valid_i[gi] & ready_c[gi];

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= RT_IDLE;
                route <= '0;
            end else if (accept) begin
                case (state)
                    RT_IDLE: begin
                        if (!bus.s_last_i[gi]) begin
                            if (bad_dest) begin
                                state <= RT_DROP;
                            end else begin
                                state <= RT_BUSY;
                                route <= dest;
                            end
                        end
                    end
                    default: begin
                        if (bus.s_last_i[gi]) state <= RT_IDLE;
                    end
                endcase
            end
        end
    end

    for (genvar gj = 0; gj < M; gj++) begin : g_mst
        logic [W-1:0]  data_q;
        logic [IW-1:0] id_q;
        logic          last_q;
        logic          valid_q;
        logic          load;

        for (genvar gi = 0; gi < S; gi++) begin : g_req
            assign req[gj][gi] = fwd_c[gi] & (target[gi] == DW'(gj));
        end

        xbar_arbiter #(
            .S_COUNT  (S),
            .IDX_W    (IW),
            .ARB_MODE (ARB_MODE)
        ) u_arb (
            .clk      (clk),
            .rst      (rst),
            .req      (req[gj]),
            .req_last (bus.s_last_i),
            .advance  (stage_ready[gj]),
            .grant_c  (grant[gj]),
            .sel_c    (sel[gj])
        );

        assign stage_ready[gj] = ~valid_q | bus.m_ready_i[gj];
        assign load            = (|grant[gj]) & stage_ready[gj];

        // Output register: load on transfer, otherwise drain on downstream handshake.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q  <= '0;
                id_q    <= '0;
                last_q  <= 1'b0;
                valid_q <= 1'b0;
            end else if (load) begin
                data_q  <= s_data[sel[gj]];
                id_q    <= sel[gj];
                last_q  <= bus.s_last_i[sel[gj]];
                valid_q <= 1'b1;
            end else if (bus.m_ready_i[gj]) begin
                valid_q <= 1'b0;
            end
        end

        assign bus.m_data_o[slice_lo(gj, W) +: W]   = data_q;
        assign bus.m_id_o[slice_lo(gj, IW) +: IW]   = id_q;
        assign bus.m_last_o[gj]                     = last_q;
        assign bus.m_valid_o[gj]                    = valid_q;
    end

    assign bus.s_ready_o = rst ? '0 : ready_c;
    assign bus.s_drop_o  = rst ? '0 : drop_c;

endmodule

// File: tb/tb_stream_xbar_reg.sv
// Directed bench for stream_xbar_reg: one round-robin and one fixed-priority instance.
module tb_stream_xbar_reg;

    localparam int unsigned W  = 8;
    localparam int unsigned S  = 3;
    localparam int unsigned M  = 5;
    localparam int unsigned IW = 2;
    localparam int unsigned DW = 3;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    stream_xbar_reg_if #(.T_DATA_WIDTH(W), .S_DATA_COUNT(S), .M_DATA_COUNT(M),
                         .T_ID___WIDTH(IW), .T_DEST_WIDTH(DW)) ifa ();
    stream_xbar_reg_if #(.T_DATA_WIDTH(W), .S_DATA_COUNT(S), .M_DATA_COUNT(M),
                         .T_ID___WIDTH(IW), .T_DEST_WIDTH(DW)) ifb ();

    stream_xbar_reg #(.T_DATA_WIDTH(W), .S_DATA_COUNT(S), .M_DATA_COUNT(M),
                      .T_ID___WIDTH(IW), .T_DEST_WIDTH(DW), .ARB_MODE(0)) dut_rr (
        .clk (clk), .rst (rst), .bus (ifa)
    );

    stream_xbar_reg #(.T_DATA_WIDTH(W), .S_DATA_COUNT(S), .M_DATA_COUNT(M),
                      .T_ID___WIDTH(IW), .T_DEST_WIDTH(DW), .ARB_MODE(1)) dut_fx (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        ifa.s_valid_i = '0; ifa.s_data_i = '0; ifa.s_dest_i = '0; ifa.s_last_i = '0;
        ifa.m_ready_i = '1;
        ifb.s_valid_i = '0; ifb.s_data_i = '0; ifb.s_dest_i = '0; ifb.s_last_i = '0;
        ifb.m_ready_i = '1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: request present while rst is high must see ready=0, outputs cleared.
        rst = 1'b1;
        idle_inputs();
        ifa.s_valid_i = 3'b001;
        tick();
        settle();
        chk("rst_s_ready", 64'(ifa.s_ready_o), 64'h0);
        tick();
        chk("rst_m_valid", 64'(ifa.m_valid_o), 64'h0);
        chk("rst_m_data",  64'(ifa.m_data_o),  64'h0);
        chk("rst_m_id",    64'(ifa.m_id_o),    64'h0);
        chk("rst_m_last",  64'(ifa.m_last_o),  64'h0);
        chk("rst_s_drop",  64'(ifa.s_drop_o),  64'h0);
        rst = 1'b0;
        ifa.s_valid_i = '0;

        // Parallel routing.
        ifa.s_valid_i = 3'b111;
        ifa.s_data_i  = {8'hFF, 8'hAA, 8'hF0};
        ifa.s_dest_i  = {3'd2, 3'd1, 3'd0};
        ifa.s_last_i  = 3'b111;
        settle();
        chk("par_s_ready", 64'(ifa.s_ready_o), 64'h7);
        chk("par_s_drop",  64'(ifa.s_drop_o),  64'h0);
        tick();
        chk("par_m_valid", 64'(ifa.m_valid_o), 64'h07);
        chk("par_m_data",  64'(ifa.m_data_o),  64'h00_00_FF_AA_F0);
        chk("par_m_id",    64'(ifa.m_id_o),    64'h024);
        do_reset();

        // Contention on master 0: round-robin vs fixed priority.
        ifa.s_valid_i = 3'b111; ifb.s_valid_i = 3'b111;
        ifa.s_data_i  = {8'hFF, 8'hAA, 8'hF0}; ifb.s_data_i = {8'hFF, 8'hAA, 8'hF0};
        ifa.s_dest_i  = '0; ifb.s_dest_i = '0;
        ifa.s_last_i  = 3'b111; ifb.s_last_i = 3'b111;
        settle();
        chk("rr_ready0", 64'(ifa.s_ready_o), 64'h1);
        chk("fx_ready0", 64'(ifb.s_ready_o), 64'h1);
        tick();
        chk("rr_data0", 64'(ifa.m_data_o[7:0]), 64'hF0);
        chk("rr_id0",   64'(ifa.m_id_o[1:0]),   64'h0);
        chk("fx_id0",   64'(ifb.m_id_o[1:0]),   64'h0);
        settle();
        chk("rr_ready1", 64'(ifa.s_ready_o), 64'h2);
        chk("fx_ready1", 64'(ifb.s_ready_o), 64'h1);
        tick();
        chk("rr_data1", 64'(ifa.m_data_o[7:0]), 64'hAA);
        chk("rr_id1",   64'(ifa.m_id_o[1:0]),   64'h1);
        chk("fx_id1",   64'(ifb.m_id_o[1:0]),   64'h0);
        chk("fx_data1", 64'(ifb.m_data_o[7:0]), 64'hF0);
        settle();
        chk("rr_ready2", 64'(ifa.s_ready_o), 64'h4);
        chk("fx_ready2", 64'(ifb.s_ready_o), 64'h1);
        tick();
        chk("rr_data2", 64'(ifa.m_data_o[7:0]), 64'hFF);
        chk("rr_id2",   64'(ifa.m_id_o[1:0]),   64'h2);
        chk("fx_id2",   64'(ifb.m_id_o[1:0]),   64'h0);
        do_reset();

        // Packet lock on master 3 and route latching on slave 0.
        ifa.s_valid_i = 3'b011;
        ifa.s_dest_i  = {3'd0, 3'd3, 3'd3};
        ifa.s_data_i  = {8'h00, 8'h22, 8'h11};
        ifa.s_last_i  = 3'b010;
        settle();
        chk("lock_ready_b1", 64'(ifa.s_ready_o), 64'h1);
        tick();
        chk("lock_valid_b1", 64'(ifa.m_valid_o), 64'h08);
        chk("lock_data_b1",  64'(ifa.m_data_o[31:24]), 64'h11);
        chk("lock_id_b1",    64'(ifa.m_id_o[7:6]), 64'h0);
        ifa.s_dest_i = {3'd0, 3'd3, 3'd1};
        ifa.s_data_i = {8'h00, 8'h22, 8'h12};
        settle();
        chk("lock_ready_b2", 64'(ifa.s_ready_o), 64'h1);
        tick();
        chk("lock_valid_b2", 64'(ifa.m_valid_o), 64'h08);
        chk("lock_data_b2",  64'(ifa.m_data_o[31:24]), 64'h12);
        ifa.s_data_i = {8'h00, 8'h22, 8'h13};
        ifa.s_last_i = 3'b011;
        settle();
        chk("lock_ready_b3", 64'(ifa.s_ready_o), 64'h1);
        tick();
        chk("lock_data_b3", 64'(ifa.m_data_o[31:24]), 64'h13);
        chk("lock_last_b3", 64'(ifa.m_last_o), 64'h08);
        ifa.s_valid_i = 3'b010;
        settle();
        chk("lock_ready_s1", 64'(ifa.s_ready_o), 64'h2);
        tick();
        chk("lock_data_s1", 64'(ifa.m_data_o[31:24]), 64'h22);
        chk("lock_id_s1",   64'(ifa.m_id_o[7:6]), 64'h1);
        chk("lock_last_s1", 64'(ifa.m_last_o[3]), 64'h1);
        do_reset();

        // Out-of-range destination: two beats dropped, then a normal packet.
        ifa.s_valid_i = 3'b100;
        ifa.s_dest_i  = {3'd6, 3'd0, 3'd0};
        ifa.s_data_i  = {8'h77, 8'h00, 8'h00};
        ifa.s_last_i  = 3'b000;
        settle();
        chk("drop_ready_b1", 64'(ifa.s_ready_o), 64'h4);
        chk("drop_pulse_b1", 64'(ifa.s_drop_o),  64'h4);
        tick();
        chk("drop_valid_b1", 64'(ifa.m_valid_o), 64'h0);
        ifa.s_dest_i = '0;
        ifa.s_last_i = 3'b100;
        settle();
        chk("drop_ready_b2", 64'(ifa.s_ready_o), 64'h4);
        chk("drop_pulse_b2", 64'(ifa.s_drop_o),  64'h4);
        tick();
        chk("drop_valid_b2", 64'(ifa.m_valid_o), 64'h0);
        ifa.s_dest_i = {3'd4, 3'd0, 3'd0};
        ifa.s_data_i = {8'h55, 8'h00, 8'h00};
        settle();
        chk("drop_after_pulse", 64'(ifa.s_drop_o),  64'h0);
        chk("drop_after_ready", 64'(ifa.s_ready_o), 64'h4);
        tick();
        chk("drop_after_valid", 64'(ifa.m_valid_o), 64'h10);
        chk("drop_after_data",  64'(ifa.m_data_o[39:32]), 64'h55);
        do_reset();

        // Backpressure on master 0 for three cycles mid-packet.
        ifa.s_valid_i = 3'b001;
        ifa.s_dest_i  = '0;
        ifa.s_data_i  = {16'h0, 8'hA1};
        ifa.s_last_i  = 3'b000;
        settle();
        chk("bp_ready_a1", 64'(ifa.s_ready_o), 64'h1);
        tick();
        ifa.s_data_i  = {16'h0, 8'hA2};
        ifa.m_ready_i = 5'b11110;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("bp_hold_ready", 64'(ifa.s_ready_o), 64'h0);
            chk("bp_hold_data",  64'(ifa.m_data_o[7:0]), 64'hA1);
            chk("bp_hold_valid", 64'(ifa.m_valid_o), 64'h01);
            chk("bp_hold_last",  64'(ifa.m_last_o), 64'h0);
            chk("bp_hold_id",    64'(ifa.m_id_o[1:0]), 64'h0);
            tick();
        end
        ifa.m_ready_i = '1;
        settle();
        chk("bp_resume_ready", 64'(ifa.s_ready_o), 64'h1);
        chk("bp_resume_data",  64'(ifa.m_data_o[7:0]), 64'hA1);
        tick();
        chk("bp_data_a2", 64'(ifa.m_data_o[7:0]), 64'hA2);
        ifa.s_data_i = {16'h0, 8'hA3};
        tick();
        chk("bp_data_a3", 64'(ifa.m_data_o[7:0]), 64'hA3);
        ifa.s_data_i = {16'h0, 8'hA4};
        ifa.s_last_i = 3'b001;
        tick();
        chk("bp_data_a4", 64'(ifa.m_data_o[7:0]), 64'hA4);
        chk("bp_last_a4", 64'(ifa.m_last_o), 64'h01);
        ifa.s_valid_i = '0;
        tick();
        chk("bp_drained", 64'(ifa.m_valid_o), 64'h0);
        do_reset();

        // Reset in the middle of a packet on master 1.
        ifa.s_valid_i = 3'b001;
        ifa.s_dest_i  = {3'd0, 3'd0, 3'd1};
        ifa.s_data_i  = {16'h0, 8'hB1};
        ifa.s_last_i  = 3'b000;
        settle();
        chk("mid_ready_b1", 64'(ifa.s_ready_o), 64'h1);
        tick();
        chk("mid_valid_b1", 64'(ifa.m_valid_o), 64'h02);
        chk("mid_data_b1",  64'(ifa.m_data_o[15:8]), 64'hB1);
        ifa.s_data_i = {16'h0, 8'hB2};
        rst = 1'b1;
        settle();
        chk("mid_rst_ready", 64'(ifa.s_ready_o), 64'h0);
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(ifa.m_valid_o), 64'h0);
        ifa.s_valid_i = 3'b010;
        ifa.s_dest_i  = {3'd0, 3'd1, 3'd1};
        ifa.s_data_i  = {8'h00, 8'hC1, 8'hB2};
        ifa.s_last_i  = 3'b010;
        settle();
        chk("mid_new_ready", 64'(ifa.s_ready_o), 64'h2);
        tick();
        chk("mid_new_valid", 64'(ifa.m_valid_o), 64'h02);
        chk("mid_new_data",  64'(ifa.m_data_o[15:8]), 64'hC1);
        chk("mid_new_id",    64'(ifa.m_id_o[3:2]), 64'h1);
        chk("mid_new_last",  64'(ifa.m_last_o), 64'h02);
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
